mc_control_fsm: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS32 control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle.
- Drives the PC, IR, ALU mux selects, register-bank write and a req/ack memory handshake with wait states.
- Sits between the shared memory port, the IR register and the datapath. Uses the same opcode encoding as the single-cycle core.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mem_wait_timer.sv | 48 ++++
 rtl/mc_control_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 control path.
// Holds the opcode map used by both the single-cycle decoder and the
// multi-cycle sequencer, the sequencer state encoding, PC source codes and
// small opcode-class helpers.
package mips_pkg;

  // Opcode map (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_JUMP  = 6'b001111;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // PC source select
  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Encoding is visible on dbg_state, so values are pinned.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StBranch = 3'd5,
    StJump   = 3'd6,
    StHalt   = 3'd7
  } state_e;

  function automatic logic is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_SLTI};
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return op inside {OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state watchdog.
// Counts consecutive cycles where a request is pending without an ack and
// flags a timeout on the WAIT_LIMIT-th such cycle. An ack in that same cycle
// suppresses the timeout. WAIT_LIMIT = 0 disables the timeout.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   req     - memory request pending
//   ack     - memory acknowledge
//   timeout - limit reached this cycle (combinational)
module mem_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned WCNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam bit Enabled = (WAIT_LIMIT != 0);
  localparam logic [WCNT_W-1:0] LastCnt = WCNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              stalled;

  assign stalled = req & ~ack;

  // Clears whenever the request completes or is dropped; saturates at the limit.
  always_comb begin
    cnt_d = '0;
    if (stalled) begin
      cnt_d = (cnt_q == LastCnt) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = Enabled && stalled && (cnt_q == LastCnt);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 control sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB (or BRANCH/JUMP)
// and drives PC/IR load, ALU selects, register write-back and a req/ack
// memory handshake with a wait-state watchdog.
// Most outputs are registered from the next state; ir_wr and pc_wr are
// combinational so they can react to mem_ack (FETCH) and eqz (BRANCH).
// Optional build macro ILLEGAL_OP_TRAP_EN: undefined opcodes halt the core
// and raise the sticky illegal_op output; otherwise they act as NOPs.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   ir                 - instruction register contents
//   eqz                - rs1 == 0 flag
//   mem_ack            - memory acknowledge
//   mem_req, mem_we    - memory request / write enable
//   iord               - address select (0 PC, 1 ALU)
//   ir_wr, pc_wr       - IR / PC load strobes
//   pc_src             - PC source (PC+4, branch, jump)
//   alu_sel_a/b, alu_op- ALU operand selects and opcode
//   reg_wr, wb_sel, rd - register write-back control
//   halted, mem_err    - status (mem_err sticky)
//   illegal_op         - sticky illegal-opcode flag (trap builds only)
//   dbg_state          - current state
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int unsigned OP_W       = 6,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned WCNT_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ir,
  input  logic            eqz,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            ir_wr,
  output logic            pc_wr,
  output logic [1:0]      pc_src,
  output logic            alu_sel_a,
  output logic            alu_sel_b,
  output logic [OP_W-1:0] alu_op,
  output logic            reg_wr,
  output logic            wb_sel,
  output logic [RA_W-1:0] rd,
  output logic            halted,
  output logic            mem_err,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic            illegal_op,
`endif
  output logic [2:0]      dbg_state
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d, ir_op;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, iord_q, iord_d;
  logic [1:0]        pc_src_q, pc_src_d;
  logic              sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic              reg_wr_q, reg_wr_d, wb_sel_q, wb_sel_d;
  logic              halted_q, halted_d, mem_err_q, mem_err_d;
  logic              fire, timeout, br_take;
`ifdef ILLEGAL_OP_TRAP_EN
  logic              illegal_q, illegal_d;
`endif

  // Register fields not consumed by the control path.
  logic unused_ir;
  assign unused_ir = ^{ir[25:21], ir[10:0]};

  assign ir_op = ir[31 -: OP_W];
  // Ack only counts while a request is actually outstanding.
  assign fire  = mem_req_q & mem_ack;

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .WCNT_W    (WCNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .req    (mem_req_q),
    .ack    (mem_ack),
    .timeout(timeout)
  );

  // Next state, opcode/rd latch
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (fire)         state_d = StDecode;
        else if (timeout) state_d = StHalt;
      end
      StDecode: begin
        op_d = ir_op;
        rd_d = is_rtype(ir_op) ? ir[15 -: RA_W] : ir[20 -: RA_W];
        if (ir_op == OP_HLT) begin
          state_d = StHalt;
        end else if (is_rtype(ir_op) || is_imm(ir_op) || is_mem(ir_op)) begin
          state_d = StExec;
        end else if (ir_op == OP_BEQZ || ir_op == OP_BNEQZ) begin
          state_d = StBranch;
        end else if (ir_op == OP_JUMP) begin
          state_d = StJump;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_d   = StHalt;
          illegal_d = 1'b1;
`else
          state_d = StFetch;
`endif
        end
      end
      StExec:   state_d = is_mem(op_q) ? StMem : StWb;
      StMem: begin
        if (fire)         state_d = (op_q == OP_SW) ? StFetch : StWb;
        else if (timeout) state_d = StHalt;
      end
      StWb, StBranch, StJump: state_d = StFetch;
      StHalt:   state_d = StHalt;
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    iord_d    = 1'b0;
    pc_src_d  = PC_SRC_PC4;
    sel_a_d   = 1'b1;
    sel_b_d   = 1'b0;
    reg_wr_d  = 1'b0;
    wb_sel_d  = 1'b1;
    halted_d  = 1'b0;
    mem_err_d = mem_err_q | timeout;
    unique case (state_d)
      StFetch:  mem_req_d = 1'b1;
      StExec:   sel_b_d = ~is_rtype(op_d);
      StMem: begin
        mem_req_d = 1'b1;
        iord_d    = 1'b1;
        mem_we_d  = (op_d == OP_SW);
      end
      StWb: begin
        reg_wr_d = 1'b1;
        wb_sel_d = (op_d != OP_LW);
      end
      StBranch: begin
        sel_a_d  = 1'b0;
        sel_b_d  = 1'b1;
        pc_src_d = PC_SRC_BRANCH;
      end
      StJump:   pc_src_d = PC_SRC_JUMP;
      StHalt:   halted_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      op_q      <= '0;
      rd_q      <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      iord_q    <= 1'b0;
      pc_src_q  <= PC_SRC_PC4;
      sel_a_q   <= 1'b1;
      sel_b_q   <= 1'b0;
      reg_wr_q  <= 1'b0;
      wb_sel_q  <= 1'b1;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      iord_q    <= iord_d;
      pc_src_q  <= pc_src_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      reg_wr_q  <= reg_wr_d;
      wb_sel_q  <= wb_sel_d;
      halted_q  <= halted_d;
      mem_err_q <= mem_err_d;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign br_take = (op_q == OP_BEQZ) ? eqz : ~eqz;

  assign ir_wr = (state_q == StFetch) & fire;
  assign pc_wr = ir_wr | (state_q == StJump) | ((state_q == StBranch) & br_take);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign iord      = iord_q;
  assign pc_src    = pc_src_q;
  assign alu_sel_a = sel_a_q;
  assign alu_sel_b = sel_b_q;
  assign alu_op    = op_q;
  assign reg_wr    = reg_wr_q;
  assign wb_sel    = wb_sel_q;
  assign rd        = rd_q;
  assign halted    = halted_q;
  assign mem_err   = mem_err_q;
  assign dbg_state = state_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: inputs change 1 time unit after the
// rising edge, outputs are checked at that point.
module tb_mc_control_fsm;

  localparam logic [5:0] T_ADD = 6'b000000, T_OR = 6'b000011, T_LW = 6'b001000;
  localparam logic [5:0] T_SW = 6'b001001, T_ADDI = 6'b001010, T_BNEQZ = 6'b001101;
  localparam logic [5:0] T_BEQZ = 6'b001110, T_JUMP = 6'b001111, T_HLT = 6'b111111;
  localparam logic [5:0] T_BAD = 6'b010000;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4, S_BRANCH = 3'd5, S_JUMP = 3'd6, S_HALT = 3'd7;

  logic        clk = 1'b0;
  logic        rst, eqz, mem_ack;
  logic [31:0] ir;
  logic        mem_req, mem_we, iord, ir_wr, pc_wr, alu_sel_a, alu_sel_b;
  logic        reg_wr, wb_sel, halted, mem_err;
  logic [1:0]  pc_src;
  logic [5:0]  alu_op;
  logic [4:0]  rd;
  logic [2:0]  dbg_state;
`ifdef ILLEGAL_OP_TRAP_EN
  logic        illegal_op;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk      (clk),
    .rst      (rst),
    .ir       (ir),
    .eqz      (eqz),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .iord     (iord),
    .ir_wr    (ir_wr),
    .pc_wr    (pc_wr),
    .pc_src   (pc_src),
    .alu_sel_a(alu_sel_a),
    .alu_sel_b(alu_sel_b),
    .alu_op   (alu_op),
    .reg_wr   (reg_wr),
    .wb_sel   (wb_sel),
    .rd       (rd),
    .halted   (halted),
    .mem_err  (mem_err),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rdf);
    return {op, rs, rt, rdf, 11'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the FSM in FETCH with mem_req already high.
  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; eqz = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Zero-wait fetch; returns in DECODE.
  task automatic fetch(input logic [31:0] instr);
    mem_ack = 1'b1; ir = instr;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; ir = 32'hFFFF_FFFF; eqz = 1'b1;
    tick(); tick();
    total++;
    if ({mem_req, mem_we, iord, ir_wr, pc_wr, reg_wr, halted, mem_err} !== 8'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b want 00000000",
               {mem_req, mem_we, iord, ir_wr, pc_wr, reg_wr, halted, mem_err});
    end
    total++;
    if ({pc_src, alu_sel_a, alu_sel_b, wb_sel, alu_op, rd, dbg_state} !==
        {2'd0, 1'b1, 1'b0, 1'b1, 6'd0, 5'd0, S_FETCH}) begin
      bad++;
      $display("FAIL reset_fields: got %h want %h",
               {pc_src, alu_sel_a, alu_sel_b, wb_sel, alu_op, rd, dbg_state},
               {2'd0, 1'b1, 1'b0, 1'b1, 6'd0, 5'd0, S_FETCH});
    end
`ifdef ILLEGAL_OP_TRAP_EN
    total++;
    if (illegal_op !== 1'b0) begin
      bad++; $display("FAIL reset_illegal: got %b want 0", illegal_op);
    end
`endif
    // Ack with no outstanding request must be ignored.
    rst = 1'b0;
    #1;
    total++;
    if (ir_wr !== 1'b0) begin bad++; $display("FAIL stray_ack_irwr: got %b want 0", ir_wr); end
    tick();
    mem_ack = 1'b0;
    #1;
    total++;
    if ({dbg_state, mem_req} !== {S_FETCH, 1'b1}) begin
      bad++; $display("FAIL post_reset_fetch: got %h want %h", {dbg_state, mem_req}, {S_FETCH, 1'b1});
    end
  endtask

  task automatic test_alu_add();
    do_reset();
    mem_ack = 1'b1; ir = mk(T_ADD, 5'd1, 5'd2, 5'd3);
    #1;
    total++;
    if ({dbg_state, ir_wr, pc_wr, pc_src, iord, mem_we} !== {S_FETCH, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_fetch: got %h want %h", {dbg_state, ir_wr, pc_wr, pc_src, iord, mem_we},
                      {S_FETCH, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
    end
    tick(); mem_ack = 1'b0; #1;
    total++;
    if ({dbg_state, mem_req, ir_wr, pc_wr} !== {S_DECODE, 3'b000}) begin
      bad++; $display("FAIL add_decode: got %h want %h", {dbg_state, mem_req, ir_wr, pc_wr}, {S_DECODE, 3'b000});
    end
    tick();
    total++;
    if ({dbg_state, alu_op, alu_sel_a, alu_sel_b, reg_wr} !== {S_EXEC, T_ADD, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_exec: got %h want %h", {dbg_state, alu_op, alu_sel_a, alu_sel_b, reg_wr},
                      {S_EXEC, T_ADD, 1'b1, 1'b0, 1'b0});
    end
    tick();
    total++;
    if ({dbg_state, reg_wr, wb_sel, rd} !== {S_WB, 1'b1, 1'b1, 5'd3}) begin
      bad++; $display("FAIL add_wb: got %h want %h", {dbg_state, reg_wr, wb_sel, rd}, {S_WB, 1'b1, 1'b1, 5'd3});
    end
    tick();
    total++;
    if ({dbg_state, reg_wr, mem_req} !== {S_FETCH, 1'b0, 1'b1}) begin
      bad++; $display("FAIL add_refetch: got %h want %h", {dbg_state, reg_wr, mem_req}, {S_FETCH, 1'b0, 1'b1});
    end
  endtask

  task automatic test_lw();
    do_reset();
    fetch(mk(T_LW, 5'd1, 5'd5, 5'd0));
    tick();
    total++;
    if ({dbg_state, alu_op, alu_sel_b} !== {S_EXEC, T_LW, 1'b1}) begin
      bad++; $display("FAIL lw_exec: got %h want %h", {dbg_state, alu_op, alu_sel_b}, {S_EXEC, T_LW, 1'b1});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      total++;
      if ({dbg_state, mem_req, iord, mem_we} !== {S_MEM, 3'b110}) begin
        bad++; $display("FAIL lw_mem_hold[%0d]: got %h want %h", i, {dbg_state, mem_req, iord, mem_we},
                        {S_MEM, 3'b110});
      end
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if ({dbg_state, reg_wr, wb_sel, rd, mem_req} !== {S_WB, 1'b1, 1'b0, 5'd5, 1'b0}) begin
      bad++; $display("FAIL lw_wb: got %h want %h", {dbg_state, reg_wr, wb_sel, rd, mem_req},
                      {S_WB, 1'b1, 1'b0, 5'd5, 1'b0});
    end
    tick();
    total++;
    if (dbg_state !== S_FETCH) begin bad++; $display("FAIL lw_refetch: got %h want %h", dbg_state, S_FETCH); end
  endtask

  task automatic test_sw();
    do_reset();
    fetch(mk(T_SW, 5'd1, 5'd6, 5'd0));
    tick(); tick();
    mem_ack = 1'b1; #1;
    total++;
    if ({dbg_state, mem_req, iord, mem_we} !== {S_MEM, 3'b111}) begin
      bad++; $display("FAIL sw_mem: got %h want %h", {dbg_state, mem_req, iord, mem_we}, {S_MEM, 3'b111});
    end
    tick(); mem_ack = 1'b0; #1;
    total++;
    if ({dbg_state, reg_wr, mem_we, mem_req} !== {S_FETCH, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sw_done: got %h want %h", {dbg_state, reg_wr, mem_we, mem_req},
                      {S_FETCH, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4];
    logic       zs  [4];
    logic       exp [4];
    ops[0] = T_BEQZ;  zs[0] = 1'b1; exp[0] = 1'b1;
    ops[1] = T_BEQZ;  zs[1] = 1'b0; exp[1] = 1'b0;
    ops[2] = T_BNEQZ; zs[2] = 1'b1; exp[2] = 1'b0;
    ops[3] = T_BNEQZ; zs[3] = 1'b0; exp[3] = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch(mk(ops[i], 5'd4, 5'd0, 5'd0));
      tick();
      eqz = zs[i]; #1;
      total++;
      if ({dbg_state, pc_wr, pc_src, alu_sel_a, alu_sel_b} !== {S_BRANCH, exp[i], 2'd1, 1'b0, 1'b1}) begin
        bad++; $display("FAIL branch[%0d]: got %h want %h", i, {dbg_state, pc_wr, pc_src, alu_sel_a, alu_sel_b},
                        {S_BRANCH, exp[i], 2'd1, 1'b0, 1'b1});
      end
      tick();
      total++;
      if ({dbg_state, mem_req} !== {S_FETCH, 1'b1}) begin
        bad++; $display("FAIL branch_refetch[%0d]: got %h want %h", i, {dbg_state, mem_req}, {S_FETCH, 1'b1});
      end
    end
  endtask

  task automatic test_jump();
    fetch(mk(T_JUMP, 5'd0, 5'd0, 5'd0));
    tick();
    total++;
    if ({dbg_state, pc_wr, pc_src} !== {S_JUMP, 1'b1, 2'd2}) begin
      bad++; $display("FAIL jump: got %h want %h", {dbg_state, pc_wr, pc_src}, {S_JUMP, 1'b1, 2'd2});
    end
    tick();
    total++;
    if ({dbg_state, pc_wr} !== {S_FETCH, 1'b0}) begin
      bad++; $display("FAIL jump_refetch: got %h want %h", {dbg_state, pc_wr}, {S_FETCH, 1'b0});
    end
  endtask

  // addi then OR with no idle cycle between instructions.
  task automatic test_back_to_back();
    fetch(mk(T_ADDI, 5'd1, 5'd7, 5'd0));
    tick(); tick();
    total++;
    if ({dbg_state, reg_wr, rd, wb_sel} !== {S_WB, 1'b1, 5'd7, 1'b1}) begin
      bad++; $display("FAIL b2b_addi_wb: got %h want %h", {dbg_state, reg_wr, rd, wb_sel}, {S_WB, 1'b1, 5'd7, 1'b1});
    end
    tick();
    fetch(mk(T_OR, 5'd2, 5'd3, 5'd9));
    tick();
    total++;
    if ({dbg_state, alu_op, alu_sel_b} !== {S_EXEC, T_OR, 1'b0}) begin
      bad++; $display("FAIL b2b_or_exec: got %h want %h", {dbg_state, alu_op, alu_sel_b}, {S_EXEC, T_OR, 1'b0});
    end
    tick();
    total++;
    if ({dbg_state, reg_wr, rd} !== {S_WB, 1'b1, 5'd9}) begin
      bad++; $display("FAIL b2b_or_wb: got %h want %h", {dbg_state, reg_wr, rd}, {S_WB, 1'b1, 5'd9});
    end
  endtask

  task automatic test_illegal();
    do_reset();
    fetch(mk(T_BAD, 5'd1, 5'd2, 5'd3));
    tick();
`ifdef ILLEGAL_OP_TRAP_EN
    total++;
    if ({dbg_state, halted, illegal_op, mem_req} !== {S_HALT, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL illegal_trap: got %h want %h", {dbg_state, halted, illegal_op, mem_req},
                      {S_HALT, 1'b1, 1'b1, 1'b0});
    end
`else
    total++;
    if ({dbg_state, reg_wr, mem_we, halted, mem_req} !== {S_FETCH, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL illegal_nop: got %h want %h", {dbg_state, reg_wr, mem_we, halted, mem_req},
                      {S_FETCH, 1'b0, 1'b0, 1'b0, 1'b1});
    end
`endif
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && mem_req === 1'b1; i++) begin
      n++;
      tick();
    end
    total++;
    if (n != 16) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 16", n); end
    tick(); tick();
    total++;
    if ({dbg_state, halted, mem_err, mem_req} !== {S_HALT, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL timeout_halt: got %h want %h", {dbg_state, halted, mem_err, mem_req},
                      {S_HALT, 1'b1, 1'b1, 1'b0});
    end
    rst = 1'b1; tick();
    total++;
    if ({dbg_state, halted, mem_err} !== {S_FETCH, 1'b0, 1'b0}) begin
      bad++; $display("FAIL timeout_clear: got %h want %h", {dbg_state, halted, mem_err}, {S_FETCH, 1'b0, 1'b0});
    end
    rst = 1'b0; tick();
    total++;
    if ({dbg_state, mem_req} !== {S_FETCH, 1'b1}) begin
      bad++; $display("FAIL timeout_restart: got %h want %h", {dbg_state, mem_req}, {S_FETCH, 1'b1});
    end
  endtask

  // Ack on the 16th wait cycle beats the timeout.
  task automatic test_ack_at_limit();
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    mem_ack = 1'b1; ir = mk(T_ADD, 5'd1, 5'd2, 5'd3); #1;
    total++;
    if ({ir_wr, dbg_state} !== {1'b1, S_FETCH}) begin
      bad++; $display("FAIL limit_ack_irwr: got %h want %h", {ir_wr, dbg_state}, {1'b1, S_FETCH});
    end
    tick(); mem_ack = 1'b0; #1;
    total++;
    if ({dbg_state, mem_err, halted} !== {S_DECODE, 1'b0, 1'b0}) begin
      bad++; $display("FAIL limit_ack_wins: got %h want %h", {dbg_state, mem_err, halted}, {S_DECODE, 1'b0, 1'b0});
    end
  endtask

  task automatic test_halt_and_reset();
    do_reset();
    fetch({T_HLT, 26'd0});
    tick();
    for (int i = 0; i < 100; i++) begin
      mem_ack = i[0]; eqz = i[1]; #1;
      total++;
      if ({halted, mem_req, mem_we, ir_wr, pc_wr, reg_wr} !== 6'b100000) begin
        bad++; $display("FAIL halt_quiet[%0d]: got %b want 100000", i, {halted, mem_req, mem_we, ir_wr, pc_wr, reg_wr});
      end
      tick();
    end
    do_reset();
    fetch(mk(T_LW, 5'd1, 5'd5, 5'd0));
    tick(); tick();
    total++;
    if ({dbg_state, mem_req} !== {S_MEM, 1'b1}) begin
      bad++; $display("FAIL midmem_pre: got %h want %h", {dbg_state, mem_req}, {S_MEM, 1'b1});
    end
    rst = 1'b1; tick();
    total++;
    if ({dbg_state, mem_req, iord} !== {S_FETCH, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midmem_reset: got %h want %h", {dbg_state, mem_req, iord}, {S_FETCH, 1'b0, 1'b0});
    end
    rst = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; eqz = 1'b0; mem_ack = 1'b0; ir = '0;
    test_reset();
    test_alu_add();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_ack_at_limit();
    test_halt_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
